apb_reg_file: RTL and testbench
===============================

# apb_reg_file

Register file on the register side of the APB slave. It consumes the slave's RegADDR/RegENABLE/RegWRITE/RegWDATA/RegSTRB request and returns RegREADY/RegRDATA/RegSLVERR after a programmable number of wait states. It holds NUM_REGS word registers:
- index 0 is a read-only ID register.
- index 1 is a read-only committed-write counter.
- the remaining registers are read/write with byte strobes.

## Interface
Parameters:
- ADDR_WIDTH, 32, width of RegADDR
- DATA_WIDTH, 32, register width
- STRB_WIDTH, DATA_WIDTH/8, byte strobe width
- NUM_REGS, 16, number of word registers (≥2)
- WAIT_STATES, 1, wait cycles inserted before RegREADY (0..15)
- ID_VALUE, 32'hA9B0_0001, constant returned by register 0

Ports:
- PCLK  in  1  clock
- PRESETn  in  1  reset, asynchronous, active-low
- RegADDR  in  ADDR_WIDTH  byte address
- RegENABLE  in  1  access phase active
- RegWRITE  in  1  1 = write, 0 = read
- RegWDATA  in  DATA_WIDTH  write data
- RegSTRB  in  STRB_WIDTH  byte enables
- RegREADY  out  1  transfer complete, one-cycle pulse
- RegRDATA  out  DATA_WIDTH  read data, valid only while RegREADY=1
- RegSLVERR  out  1  error, valid only while RegREADY=1

## Operation
- **Reset:** RegREADY=0, RegRDATA=0, RegSLVERR=0, all registers=0, write counter=0, state IDLE, enable_q=0.
- **Address decode:** idx = RegADDR[ADDR_WIDTH-1:2].
  - bad_addr = (RegADDR[1:0]≠0) or (idx ≥ NUM_REGS).
  - ro_wr = RegWRITE and idx<2.
- **FSM states:** IDLE, WAIT, RESP.
  - enable_q is RegENABLE registered every cycle.
  - start = RegENABLE & !enable_q.
  - IDLE: if start and WAIT_STATES=0, go to RESP; if start and WAIT_STATES>0, go to WAIT and load cnt=WAIT_STATES-1.
  - WAIT: if RegENABLE=0, abort to IDLE with no side effects. Otherwise, if cnt=0 go to RESP, else cnt-1.
  - RESP: go to IDLE unconditionally.
- **Response registers:** RegRDATA and RegSLVERR are loaded on the edge that enters RESP and cleared to 0 on the edge leaving RESP. RegREADY = (state==RESP).
- **Write commit:** happens on the edge entering RESP, only when not bad_addr and not ro_wr.
  - For each byte i, reg[idx][8i+7:8i] is written only where RegSTRB[i]=1.
  - The write counter increments by 1 (wraps at 2^DATA_WIDTH) on every commit, including when RegSTRB=0.
  - A write with RegSTRB=0 changes no data bytes and reports no error.
- **Read:** RegRDATA = ID_VALUE for idx 0, the write counter for idx 1, reg[idx] otherwise. Reads are side-effect free.
- **Re-arm:** RegENABLE held high after RESP does not retrigger. A new transfer requires RegENABLE to go low for at least one cycle.
- **Reset mid-transfer:** immediate return to IDLE with all outputs 0. No partial write.

## Timing
- Let cycle 0 be the first cycle with RegENABLE=1. RegREADY=1 in cycle WAIT_STATES+1, for exactly one cycle.
- Upstream access phase lasts WAIT_STATES+2 cycles. Minimum transfer spacing is one RegENABLE-low cycle.
- Write data is visible to a read whose RESP cycle falls at least one cycle after the write's RESP cycle.
- RegADDR, RegWRITE, RegWDATA and RegSTRB must be stable while RegENABLE=1. They are sampled on the edge entering RESP.

## Configuration
- Macro: APB_REG_FILE_ERR_EN.
- **Defined:** RegSLVERR=1 in RESP for bad_addr or ro_wr. Erroring reads return RegRDATA=0.
- **Undefined:** RegSLVERR is tied 0. Bad_addr or ro_wr writes are silently dropped (no counter increment). Bad_addr reads return 0.

## Structure
- Package apb_reg_file_pkg:
  - state enum (IDLE/WAIT/RESP)
  - localparams IDX_ID=0 and IDX_WRCNT=1
  - default ID_VALUE
- Sub-module: apb_reg_file_wait_ctr. It owns enable_q, start detect, the FSM and cnt, and outputs rdy_pulse and commit_en. Top level holds decode, storage and response muxing.

## Test plan
- **Reset:** assert PRESETn=0 mid-WAIT → RegREADY/RegRDATA/RegSLVERR=0. Afterwards, read idx 2 → 0 and read idx 1 → 0.
- **Write/read:** WAIT_STATES=1. Write 0x12345678 to addr 0x08 with STRB=4'hF → RegREADY in cycle 2, SLVERR=0. Read 0x08 → RDATA=0x12345678. Read 0x04 → 1.
- **Byte strobe:** write 0xAABBCCDD to 0x08 with STRB=4'b0101 → read 0x12BB56DD. Write with STRB=0 → data unchanged, counter increments to 3.
- **Errors (ERR_EN defined):**
  - read 0x40 (NUM_REGS=16) → SLVERR=1, RDATA=0
  - write 0x00 → SLVERR=1, ID still 0xA9B00001
  - read 0x09 → SLVERR=1
- **Abort/re-arm:** WAIT_STATES=3, drop RegENABLE in cycle 2 → no RegREADY, no write. Hold RegENABLE high after RESP → no second RegREADY.
- **Zero wait:** WAIT_STATES=0 → RegREADY in cycle 1. Back-to-back transfers separated by one low cycle both complete.

Source files
------------

// File: rtl/apb_reg_file_pkg.sv
// Shared types and constants for the APB register file.
// The optional SLVERR reporting is enabled by defining APB_REG_FILE_ERR_EN.
package apb_reg_file_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

  localparam int unsigned IDX_ID    = 0;
  localparam int unsigned IDX_WRCNT = 1;

  localparam logic [31:0] DEFAULT_ID_VALUE = 32'hA9B0_0001;

endpackage

// File: rtl/apb_reg_file_wait_ctr.sv
// Transfer sequencer: edge-detects RegENABLE, counts wait states and emits the
// one-cycle ready pulse plus the commit strobe on the edge that enters RESP.
module apb_reg_file_wait_ctr
  import apb_reg_file_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic PCLK,
  input  logic PRESETn,
  input  logic enable,
  output logic rdy_pulse,
  output logic commit_en
);

  localparam logic [3:0] CntLoad = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       enable_q;
  logic       start;

  assign start = enable & ~enable_q;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q  <= StIdle;
      cnt_q    <= 4'd0;
      enable_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      enable_q <= enable;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (WAIT_STATES == 0) begin
            state_d = StResp;
          end else begin
            state_d = StWait;
            cnt_d   = CntLoad;
          end
        end
      end
      // Dropping enable mid-wait abandons the transfer without any side effect.
      StWait: begin
        if (!enable) begin
          state_d = StIdle;
        end else if (cnt_q == 4'd0) begin
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rdy_pulse = (state_q == StResp);
    commit_en = (state_q != StResp) && (state_d == StResp);
  end

endmodule

// File: rtl/apb_reg_file.sv
// Register file behind the APB slave: ID register, committed-write counter and
// byte-strobed R/W registers. Define APB_REG_FILE_ERR_EN to report SLVERR.
module apb_reg_file
  import apb_reg_file_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE = DATA_WIDTH'(DEFAULT_ID_VALUE)
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic [ADDR_WIDTH-1:0] RegADDR,
  input  logic                  RegENABLE,
  input  logic                  RegWRITE,
  input  logic [DATA_WIDTH-1:0] RegWDATA,
  input  logic [STRB_WIDTH-1:0] RegSTRB,
  output logic                  RegREADY,
  output logic [DATA_WIDTH-1:0] RegRDATA,
  output logic                  RegSLVERR
);

  localparam int unsigned IdxW    = ADDR_WIDTH - 2;
  localparam int unsigned RegIdxW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic [IdxW-1:0]       idx;
  logic [RegIdxW-1:0]    reg_sel;
  logic                  bad_addr;
  logic                  ro_wr;
  logic                  do_write;
  logic                  err_hit;
  logic                  rdy_pulse;
  logic                  commit_en;
  logic [DATA_WIDTH-1:0] rd_mux;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] wr_cnt_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  slverr_q;

  apb_reg_file_wait_ctr #(
    .WAIT_STATES(WAIT_STATES)
  ) u_wait_ctr (
    .PCLK     (PCLK),
    .PRESETn  (PRESETn),
    .enable   (RegENABLE),
    .rdy_pulse(rdy_pulse),
    .commit_en(commit_en)
  );

  assign idx      = RegADDR[ADDR_WIDTH-1:2];
  assign reg_sel  = idx[RegIdxW-1:0];
  assign bad_addr = (RegADDR[1:0] != 2'b00) || (idx >= IdxW'(NUM_REGS));
  assign ro_wr    = RegWRITE && (idx <= IdxW'(IDX_WRCNT));
  assign do_write = RegWRITE && !bad_addr && !ro_wr;

`ifdef APB_REG_FILE_ERR_EN
  assign err_hit = bad_addr | ro_wr;
`else
  assign err_hit = 1'b0;
`endif

  // Bad-address reads return zero whether or not errors are reported.
  always_comb begin
    rd_mux = '0;
    if (!RegWRITE && !bad_addr) begin
      if (idx == IdxW'(IDX_ID)) begin
        rd_mux = ID_VALUE;
      end else if (idx == IdxW'(IDX_WRCNT)) begin
        rd_mux = wr_cnt_q;
      end else begin
        rd_mux = regs_q[reg_sel];
      end
    end
  end

  // Indices 0 and 1 are never written; their flops stay at reset and fold away.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      wr_cnt_q <= '0;
    end else if (commit_en && do_write) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (RegSTRB[b]) begin
          regs_q[reg_sel][8*b +: 8] <= RegWDATA[8*b +: 8];
        end
      end
      wr_cnt_q <= wr_cnt_q + DATA_WIDTH'(1);
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rdata_q  <= '0;
      slverr_q <= 1'b0;
    end else if (commit_en) begin
      rdata_q  <= rd_mux;
      slverr_q <= err_hit;
    end else if (rdy_pulse) begin
      rdata_q  <= '0;
      slverr_q <= 1'b0;
    end
  end

  assign RegREADY  = rdy_pulse;
  assign RegRDATA  = rdata_q;
  assign RegSLVERR = slverr_q;

`ifndef SYNTHESIS
  ready_is_pulse: assert property (@(posedge PCLK) disable iff (!PRESETn)
    RegREADY |=> !RegREADY);
  no_commit_in_resp: assert property (@(posedge PCLK) disable iff (!PRESETn)
    !(commit_en && rdy_pulse));
`endif

endmodule

// File: tb/tb_apb_reg_file.sv
// Bench for apb_reg_file: three instances (1, 3 and 0 wait states), a directed
// vector table, hand-written corner sequences and random traffic vs a model.
module tb_apb_reg_file;

`ifdef APB_REG_FILE_ERR_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif
  localparam logic [31:0] Id = 32'hA9B0_0001;
  localparam int NRegs = 16;

  logic        clk;
  logic        rst_n;
  logic        en      [3];
  logic        wr_s    [3];
  logic [31:0] addr_s  [3];
  logic [31:0] wdata_s [3];
  logic [3:0]  strb_s  [3];
  logic        rdy     [3];
  logic [31:0] rdata   [3];
  logic        err     [3];

  int checks = 0;
  int errors = 0;

  logic [31:0] m_regs [3][NRegs];
  logic [31:0] m_cnt  [3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  apb_reg_file #(.WAIT_STATES(1)) u_dut0 (
    .PCLK(clk), .PRESETn(rst_n), .RegADDR(addr_s[0]), .RegENABLE(en[0]), .RegWRITE(wr_s[0]),
    .RegWDATA(wdata_s[0]), .RegSTRB(strb_s[0]), .RegREADY(rdy[0]), .RegRDATA(rdata[0]),
    .RegSLVERR(err[0])
  );
  apb_reg_file #(.WAIT_STATES(3)) u_dut1 (
    .PCLK(clk), .PRESETn(rst_n), .RegADDR(addr_s[1]), .RegENABLE(en[1]), .RegWRITE(wr_s[1]),
    .RegWDATA(wdata_s[1]), .RegSTRB(strb_s[1]), .RegREADY(rdy[1]), .RegRDATA(rdata[1]),
    .RegSLVERR(err[1])
  );
  apb_reg_file #(.WAIT_STATES(0)) u_dut2 (
    .PCLK(clk), .PRESETn(rst_n), .RegADDR(addr_s[2]), .RegENABLE(en[2]), .RegWRITE(wr_s[2]),
    .RegWDATA(wdata_s[2]), .RegSTRB(strb_s[2]), .RegREADY(rdy[2]), .RegRDATA(rdata[2]),
    .RegSLVERR(err[2])
  );

  function automatic int ws_of(input int d);
    return (d == 0) ? 1 : (d == 1) ? 3 : 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      m_cnt[d] = 0;
      for (int i = 0; i < NRegs; i++) m_regs[d][i] = 0;
    end
  endtask

  // Reference behaviour from the register-map rules.
  task automatic model_xfer(input int d, input logic w, input logic [31:0] a,
                            input logic [31:0] wd, input logic [3:0] s,
                            output logic [31:0] erd, output logic eer);
    int unsigned ix;
    bit bad, ro;
    ix  = a / 4;
    bad = (a % 4 != 0) || (ix >= NRegs);
    ro  = w && (ix < 2);
    eer = ErrEn && (bad || ro);
    erd = 0;
    if (w) begin
      if (!bad && !ro) begin
        for (int b = 0; b < 4; b++)
          if (s[b]) m_regs[d][ix][8*b +: 8] = wd[8*b +: 8];
        m_cnt[d] = m_cnt[d] + 1;
      end
    end else if (!bad) begin
      erd = (ix == 0) ? Id : (ix == 1) ? m_cnt[d] : m_regs[d][ix];
    end
  endtask

  // One full transfer: enable until READY is seen, then one low cycle follows.
  task automatic xfer(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] s, output logic [31:0] rd, output logic er,
                      output int cyc);
    cyc = -1;
    rd  = 0;
    er  = 0;
    @(posedge clk); #1;
    en[d] = 1; wr_s[d] = w; addr_s[d] = a; wdata_s[d] = wd; strb_s[d] = s;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (rdy[d]) begin
        cyc = c; rd = rdata[d]; er = err[d];
        break;
      end
    end
    @(posedge clk); #1;
    en[d] = 0;
    @(negedge clk);
    chk("ready_one_cycle", 32'(rdy[d]), 32'd0);
    chk("rdata_cleared", rdata[d], 32'd0);
    chk("slverr_cleared", 32'(err[d]), 32'd0);
  endtask

  task automatic run(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] s);
    logic [31:0] erd, rd;
    logic eer, er;
    int cyc;
    model_xfer(d, w, a, wd, s, erd, eer);
    xfer(d, w, a, wd, s, rd, er, cyc);
    chk("ready_cycle", 32'(cyc), 32'(ws_of(d) + 1));
    chk("slverr", 32'(er), 32'(eer));
    if (!w) chk("rdata", rd, erd);
  endtask

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0]  s;
    logic [31:0] exp_rd;
    logic        err_if_en;
  } vec_t;

  vec_t vecs [14];

  initial begin
    logic [31:0] rd, drd;
    logic er, der;
    int cyc, pulses;
    bit seen;

    rst_n = 0;
    for (int d = 0; d < 3; d++) begin
      en[d] = 0; wr_s[d] = 0; addr_s[d] = 0; wdata_s[d] = 0; strb_s[d] = 0;
    end
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk("reset_ready", 32'(rdy[d]), 32'd0);
      chk("reset_rdata", rdata[d], 32'd0);
      chk("reset_slverr", 32'(err[d]), 32'd0);
    end
    rst_n = 1;

    // Reset asserted while instance 1 sits in WAIT: write must never land.
    @(posedge clk); #1;
    en[1] = 1; wr_s[1] = 1; addr_s[1] = 32'h08; wdata_s[1] = 32'hFFFF_FFFF; strb_s[1] = 4'hF;
    @(posedge clk); @(posedge clk); #3;
    rst_n = 0;
    #1;
    chk("midrst_ready", 32'(rdy[1]), 32'd0);
    chk("midrst_rdata", rdata[1], 32'd0);
    chk("midrst_slverr", 32'(err[1]), 32'd0);
    en[1] = 0;
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    model_reset();
    run(1, 0, 32'h08, 0, 0);
    run(1, 0, 32'h04, 0, 0);

    vecs[0]  = '{1, 32'h08, 32'h1234_5678, 4'hF, 32'h0, 0};
    vecs[1]  = '{0, 32'h08, 32'h0, 4'h0, 32'h1234_5678, 0};
    vecs[2]  = '{0, 32'h04, 32'h0, 4'h0, 32'h1, 0};
    vecs[3]  = '{1, 32'h08, 32'hAABB_CCDD, 4'b0101, 32'h0, 0};
    vecs[4]  = '{0, 32'h08, 32'h0, 4'h0, 32'h12BB_56DD, 0};
    vecs[5]  = '{1, 32'h08, 32'hFFFF_FFFF, 4'h0, 32'h0, 0};
    vecs[6]  = '{0, 32'h08, 32'h0, 4'h0, 32'h12BB_56DD, 0};
    vecs[7]  = '{0, 32'h04, 32'h0, 4'h0, 32'h3, 0};
    vecs[8]  = '{0, 32'h40, 32'h0, 4'h0, 32'h0, 1};
    vecs[9]  = '{1, 32'h00, 32'hDEAD_BEEF, 4'hF, 32'h0, 1};
    vecs[10] = '{0, 32'h00, 32'h0, 4'h0, Id, 0};
    vecs[11] = '{0, 32'h09, 32'h0, 4'h0, 32'h0, 1};
    vecs[12] = '{1, 32'h04, 32'h0000_0055, 4'hF, 32'h0, 1};
    vecs[13] = '{0, 32'h04, 32'h0, 4'h0, 32'h3, 0};
    for (int i = 0; i < 14; i++) begin
      model_xfer(0, vecs[i].w, vecs[i].a, vecs[i].wd, vecs[i].s, drd, der);
      xfer(0, vecs[i].w, vecs[i].a, vecs[i].wd, vecs[i].s, rd, er, cyc);
      chk($sformatf("vec%0d_cycle", i), 32'(cyc), 32'd2);
      chk($sformatf("vec%0d_slverr", i), 32'(er), 32'(ErrEn & vecs[i].err_if_en));
      if (!vecs[i].w) chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
    end

    // Abort: instance 1 (3 wait states) loses enable in cycle 2.
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      en[1] = (c < 2); wr_s[1] = 1; addr_s[1] = 32'h0C; wdata_s[1] = 32'h55; strb_s[1] = 4'hF;
      @(negedge clk);
      if (rdy[1]) seen = 1;
    end
    chk("abort_no_ready", 32'(seen), 32'd0);
    run(1, 0, 32'h0C, 0, 0);
    run(1, 0, 32'h04, 0, 0);

    // Re-arm: enable held high long after RESP yields a single READY.
    pulses = 0;
    @(posedge clk); #1;
    en[1] = 1; wr_s[1] = 0; addr_s[1] = 32'h00;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (rdy[1]) pulses++;
    end
    @(posedge clk); #1;
    en[1] = 0;
    chk("rearm_pulses", 32'(pulses), 32'd1);

    // Zero wait states: back-to-back writes then immediate read-back.
    run(2, 1, 32'h20, 32'hCAFE_F00D, 4'hF);
    run(2, 1, 32'h24, 32'h0BAD_1DEA, 4'b1100);
    run(2, 0, 32'h20, 0, 0);
    run(2, 0, 32'h24, 0, 0);
    run(2, 0, 32'h04, 0, 0);

    for (int n = 0; n < 300; n++) begin
      int d;
      logic [31:0] a;
      d = $urandom_range(0, 2);
      a = 32'($urandom_range(0, 17)) * 4;
      if ($urandom_range(0, 9) == 0) a = a | 32'($urandom_range(1, 3));
      run(d, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
    end
    for (int d = 0; d < 3; d++) run(d, 0, 32'h04, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
